// File: rtl/dtc_sample_sequencer.sv
// Sample sequencer for the 10-bit decision-tree classifier: packs a byte stream into
// feature vectors, captures the prediction with its label, and keeps accuracy counters.
module dtc_sample_sequencer #(
  parameter int CNT_W    = 16,
  parameter int PRED_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [9:0]       feat,
  input  logic             pred,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_pred,
  output logic             res_label,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] correct_cnt
);

  typedef enum logic [1:0] {ST_LO, ST_HI, ST_EVAL, ST_HOLD} state_t;

  localparam logic [2:0] LAT = 3'(PRED_LAT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [9:0]       feat_q, feat_d;
  logic             label_q, label_d;
  logic [2:0]       wait_q, wait_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             res_pred_q, res_pred_d;
  logic             res_label_q, res_label_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] correct_q, correct_d;

  logic xfer;
  logic res_hs;

  // Byte1 bits [6:2] carry no information for the classifier.
  logic unused_byte1_bits;
  assign unused_byte1_bits = ^in_data[6:2];

  assign xfer   = in_valid && in_ready_q;
  assign res_hs = res_valid_q && res_ready;

  always_comb begin
    state_d     = state_q;
    feat_d      = feat_q;
    label_d     = label_q;
    wait_d      = wait_q;
    in_ready_d  = in_ready_q;
    res_valid_d = res_valid_q;
    res_pred_d  = res_pred_q;
    res_label_d = res_label_q;
    total_d     = total_q;
    correct_d   = correct_q;

    unique case (state_q)
      ST_LO: begin
        if (xfer) begin
          feat_d[7:0] = in_data;
          state_d     = ST_HI;
        end
      end
      ST_HI: begin
        if (xfer) begin
          feat_d[9:8] = in_data[1:0];
          label_d     = in_data[7];
          wait_d      = LAT;
          in_ready_d  = 1'b0;
          state_d     = ST_EVAL;
        end
      end
      ST_EVAL: begin
        // feat has been stable since entry, so pred reflects this sample once the wait expires.
        if (wait_q == 3'd0) begin
          res_pred_d  = pred;
          res_label_d = label_q;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_LO;
        end
      end
      default: state_d = ST_LO;
    endcase

    // A clear discards a coincident handshake rather than counting it.
    if (clr_stats) begin
      total_d   = '0;
      correct_d = '0;
    end else if (res_hs) begin
      total_d = sat_inc(total_q);
      if (res_pred_q == res_label_q) correct_d = sat_inc(correct_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LO;
      feat_q      <= '0;
      label_q     <= 1'b0;
      wait_q      <= '0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_pred_q  <= 1'b0;
      res_label_q <= 1'b0;
      total_q     <= '0;
      correct_q   <= '0;
    end else begin
      state_q     <= state_d;
      feat_q      <= feat_d;
      label_q     <= label_d;
      wait_q      <= wait_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_pred_q  <= res_pred_d;
      res_label_q <= res_label_d;
      total_q     <= total_d;
      correct_q   <= correct_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign feat        = feat_q;
  assign res_valid   = res_valid_q;
  assign res_pred    = res_pred_q;
  assign res_label   = res_label_q;
  assign total_cnt   = total_q;
  assign correct_cnt = correct_q;

endmodule

// File: tb/tb_dtc_sample_sequencer.sv
// Directed bench: instance A (PRED_LAT=0, combinational classifier) and
// instance B (PRED_LAT=2, CNT_W=4, two-stage registered classifier model).
module tb_dtc_sample_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a_in_data;
  logic        a_in_valid, a_in_ready;
  logic [9:0]  a_feat;
  logic        a_pred;
  logic        a_res_valid, a_res_ready, a_res_pred, a_res_label;
  logic        a_clr;
  logic [15:0] a_total, a_correct;

  logic [7:0]  b_in_data;
  logic        b_in_valid, b_in_ready;
  logic [9:0]  b_feat;
  logic        b_pred;
  logic        b_res_valid, b_res_ready, b_res_pred, b_res_label;
  logic        b_clr;
  logic [3:0]  b_total, b_correct;

  logic b_s1, b_s2;

  int n_chk  = 0;
  int n_pass = 0;

  dtc_sample_sequencer #(.CNT_W(16), .PRED_LAT(0)) dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .feat(a_feat), .pred(a_pred),
    .res_valid(a_res_valid), .res_ready(a_res_ready),
    .res_pred(a_res_pred), .res_label(a_res_label),
    .clr_stats(a_clr), .total_cnt(a_total), .correct_cnt(a_correct)
  );

  dtc_sample_sequencer #(.CNT_W(4), .PRED_LAT(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .feat(b_feat), .pred(b_pred),
    .res_valid(b_res_valid), .res_ready(b_res_ready),
    .res_pred(b_res_pred), .res_label(b_res_label),
    .clr_stats(b_clr), .total_cnt(b_total), .correct_cnt(b_correct)
  );

  // Registered classifier: outp = feat[9] & feat[0], two cycles after feat.
  always_ff @(posedge clk) begin
    b_s1 <= b_feat[9] & b_feat[0];
    b_s2 <= b_s1;
  end
  assign b_pred = b_s2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [7:0] d);
    a_in_data  = d;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d);
    b_in_data  = d;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic b_wait_result();
    for (int i = 0; i < 10 && !b_res_valid; i++) tick();
    chk("b_res_valid_wait", 32'(b_res_valid), 32'd1);
  endtask

  task automatic b_sample(input logic [7:0] d0, input logic [7:0] d1);
    b_send(d0);
    b_send(d1);
    b_wait_result();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_in_data = '0; a_in_valid = 1'b0; a_pred = 1'b1; a_res_ready = 1'b1; a_clr = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_res_ready = 1'b1; b_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_res_valid", 32'(a_res_valid), 32'd0);
    chk("rst_feat", 32'(a_feat), 32'h000);
    chk("rst_res_pred", 32'(a_res_pred), 32'd0);
    chk("rst_res_label", 32'(a_res_label), 32'd0);
    chk("rst_total", 32'(a_total), 32'd0);
    chk("rst_correct", 32'(a_correct), 32'd0);

    // A: 0xA5,0x83 with classifier returning 1
    a_send(8'hA5);
    chk("a1_feat_byte0", 32'(a_feat), 32'h0A5);
    a_send(8'h83);
    chk("a1_feat", 32'(a_feat), 32'h3A5);
    chk("a1_eval_valid", 32'(a_res_valid), 32'd0);
    chk("a1_eval_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    chk("a1_res_valid", 32'(a_res_valid), 32'd1);
    chk("a1_res_label", 32'(a_res_label), 32'd1);
    chk("a1_res_pred", 32'(a_res_pred), 32'd1);
    tick();
    chk("a1_res_done", 32'(a_res_valid), 32'd0);
    chk("a1_in_ready", 32'(a_in_ready), 32'd1);
    chk("a1_total", 32'(a_total), 32'd1);
    chk("a1_correct", 32'(a_correct), 32'd1);

    // A: label 0, prediction still 1 -> not correct
    a_send(8'hA5);
    a_send(8'h03);
    chk("a2_feat", 32'(a_feat), 32'h3A5);
    tick();
    chk("a2_res_valid", 32'(a_res_valid), 32'd1);
    chk("a2_res_label", 32'(a_res_label), 32'd0);
    tick();
    chk("a2_total", 32'(a_total), 32'd2);
    chk("a2_correct", 32'(a_correct), 32'd1);

    // A: backpressure for 5 cycles, with ignored input attempts
    a_res_ready = 1'b0;
    a_send(8'hA5);
    a_send(8'h83);
    tick();
    a_in_data  = 8'h55;
    a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid", 32'(a_res_valid), 32'd1);
      chk("bp_res_pred", 32'(a_res_pred), 32'd1);
      chk("bp_res_label", 32'(a_res_label), 32'd1);
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      chk("bp_feat", 32'(a_feat), 32'h3A5);
      chk("bp_total", 32'(a_total), 32'd2);
      tick();
    end
    a_in_valid  = 1'b0;
    a_res_ready = 1'b1;
    tick();
    chk("bp_done_valid", 32'(a_res_valid), 32'd0);
    chk("bp_total_after", 32'(a_total), 32'd3);
    chk("bp_correct_after", 32'(a_correct), 32'd2);
    chk("bp_feat_after", 32'(a_feat), 32'h3A5);

    // B: PRED_LAT=2 timing with registered classifier
    b_send(8'hA5);
    b_send(8'h83);
    chk("b_feat", 32'(b_feat), 32'h3A5);
    chk("b_lat_c1", 32'(b_res_valid), 32'd0);
    tick();
    chk("b_lat_c2", 32'(b_res_valid), 32'd0);
    tick();
    chk("b_lat_c3", 32'(b_res_valid), 32'd0);
    tick();
    chk("b_lat_c4", 32'(b_res_valid), 32'd1);
    chk("b_res_pred", 32'(b_res_pred), 32'd1);
    chk("b_res_label", 32'(b_res_label), 32'd1);
    tick();
    chk("b_total1", 32'(b_total), 32'd1);
    chk("b_correct1", 32'(b_correct), 32'd1);

    // B: CNT_W=4 saturation after 20 correct samples
    for (int i = 0; i < 19; i++) b_sample(8'hA5, 8'h83);
    chk("b_sat_total", 32'(b_total), 32'd15);
    chk("b_sat_correct", 32'(b_correct), 32'd15);

    // B: clear coincident with a handshake wins
    b_send(8'hA5);
    b_send(8'h83);
    b_wait_result();
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("b_clr_total", 32'(b_total), 32'd0);
    chk("b_clr_correct", 32'(b_correct), 32'd0);
    chk("b_clr_res_valid", 32'(b_res_valid), 32'd0);
    b_sample(8'hA5, 8'h83);
    chk("b_post_clr_total", 32'(b_total), 32'd1);
    chk("b_post_clr_correct", 32'(b_correct), 32'd1);

    // A: reset in HI discards the partial 0xFF sample
    a_send(8'hFF);
    chk("r_feat_partial", 32'(a_feat), 32'h3FF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_feat", 32'(a_feat), 32'h000);
    chk("r_in_ready", 32'(a_in_ready), 32'd1);
    chk("r_total", 32'(a_total), 32'd0);
    a_send(8'h01);
    a_send(8'h00);
    chk("r_feat_new", 32'(a_feat), 32'h001);
    tick();
    chk("r_res_valid", 32'(a_res_valid), 32'd1);
    chk("r_res_label", 32'(a_res_label), 32'd0);
    chk("r_res_pred", 32'(a_res_pred), 32'd1);
    tick();
    chk("r_total_after", 32'(a_total), 32'd1);
    chk("r_correct_after", 32'(a_correct), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
